// File: rtl/alu_pipe_ody_1201462.sv
// Two-stage pipelined signed ALU with valid/ready handshakes,
// accumulator operand mode, status flags and a result counter.
module alu_pipe_ody_1201462 #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [2:0]    s,
  input  logic          acc_sel,
  input  logic          acc_wr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W+1:0]  o,
  output logic          zero,
  output logic          neg,
  output logic [CW-1:0] res_cnt
);

  localparam int RW = W + 2;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   s;
    logic         acc_sel;
    logic         acc_wr;
  } s1_t;

  s1_t          s1_q;
  logic         s1_v;
  logic [W-1:0] acc;
  logic         s1_ld;
  logic         s2_ld;

  assign s2_ld    = s1_v & (~out_valid | out_ready);
  assign in_ready = ~rst & (~s1_v | s2_ld);
  assign s1_ld    = in_valid & in_ready;

  logic [W-1:0]         xo;
  logic [W-1:0]         bw;
  logic signed [RW-1:0] xs;
  logic signed [RW-1:0] ys;
  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] xh;
  logic signed [RW-1:0] yh;
  logic signed [RW-1:0] r;

  // acc replaces X only at S2 load, so chained beats see the prior write
  assign xo  = s1_q.acc_sel ? acc : s1_q.x;
  assign xs  = {{2{xo[W-1]}}, xo};
  assign ys  = {{2{s1_q.y[W-1]}}, s1_q.y};
  assign sum = xs + ys;
  assign xh  = xs >>> 1;
  assign yh  = ys >>> 1;

  always_comb begin
    bw = '0;
    r  = '0;
    unique case (s1_q.s)
      3'b000: r = sum >>> 1;
      3'b001: r = sum <<< 1;
      3'b010: r = xh + ys;
      3'b011: r = xs - yh;
      3'b100: bw = ~(xo & s1_q.y);
      3'b101: bw = ~xo;
      3'b110: bw = ~(xo | s1_q.y);
      3'b111: bw = xo ^ s1_q.y;
      default: r = '0;
    endcase
    if (s1_q.s[2])
      r = {{2{bw[W-1]}}, bw};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s1_v      <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      o         <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      res_cnt   <= '0;
    end else begin
      if (s1_ld)
        s1_q <= '{x: x, y: y, s: s,
                  acc_sel: acc_sel,
                  acc_wr: acc_wr};
      if (s1_ld)
        s1_v <= 1'b1;
      else if (s2_ld)
        s1_v <= 1'b0;
      if (s2_ld) begin
        o         <= r;
        zero      <= (r == '0);
        neg       <= r[RW-1];
        out_valid <= 1'b1;
        if (s1_q.acc_wr)
          acc <= r[W-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid & out_ready)
        res_cnt <= res_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_pipe_ody_1201462.sv
// Directed bench for alu_pipe_ody_1201462: ops, streaming with
// backpressure, accumulator chaining, mid-flight reset, counter wrap.
module tb_alu_pipe_ody_1201462;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         acc_sel = 1'b0;
  logic         acc_wr = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [2:0]   s = '0;

  logic         in_ready, out_valid, zero, neg;
  logic [W+1:0] o;
  logic [7:0]   res_cnt;
  logic         in_ready2, out_valid2, zero2, neg2;
  logic [W+1:0] o2;
  logic [1:0]   res_cnt2;

  alu_pipe_ody_1201462 #(.W(W), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .s(s),
    .acc_sel(acc_sel), .acc_wr(acc_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .zero(zero), .neg(neg),
    .res_cnt(res_cnt)
  );

  alu_pipe_ody_1201462 #(.W(W), .CW(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .x(x), .y(y), .s(s),
    .acc_sel(acc_sel), .acc_wr(acc_wr),
    .out_valid(out_valid2), .out_ready(out_ready),
    .o(o2), .zero(zero2), .neg(neg2),
    .res_cnt(res_cnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int xv, input int yv,
                       input logic as, input logic aw);
    in_valid = 1'b1;
    s        = op[2:0];
    x        = xv[W-1:0];
    y        = yv[W-1:0];
    acc_sel  = as;
    acc_wr   = aw;
  endtask

  task automatic single(input string tag, input int op, input int xv,
                        input int yv, input logic as, input logic aw,
                        input int eo, input int ez, input int en);
    drive(op, xv, yv, as, aw);
    step;
    in_valid = 1'b0;
    step;
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_o"}, $signed(o), eo);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_neg"}, neg, en);
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    step;
    rst      = 1'b0;
  endtask

  int exp_s [8] = '{0, 2, -1, 4, -3, -4, 0, -3};

  initial begin
    int i, k, cyc, seen;

    rst = 1'b1;
    step;
    step;
    chk("rst_ov", out_valid, 0);
    chk("rst_o", $signed(o), 0);
    chk("rst_zero", zero, 0);
    chk("rst_neg", neg, 0);
    chk("rst_cnt", res_cnt, 0);
    chk("rst_ir", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_ir", in_ready, 1);

    out_ready = 1'b1;
    single("op000", 0, 5, 3, 0, 0, 4, 0, 0);
    single("op001", 1, 5, 3, 0, 0, 16, 0, 0);
    single("op001n", 1, -8, -8, 0, 0, -32, 0, 1);
    single("op010", 2, -3, 2, 0, 0, 0, 1, 0);
    single("op011", 3, 5, -3, 0, 0, 7, 0, 0);
    step;
    chk("cnt5", res_cnt, 5);
    chk("cnt5_wrap", res_cnt2, 1);
    chk("idle_ov", out_valid, 0);
    single("op100", 4, 10, 6, 0, 0, -3, 0, 1);
    step;

    do_reset;
    i   = 0;
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (i < 8)
        drive(i, 3, -2, 1'b0, 1'b0);
      else
        in_valid = 1'b0;
      #1;
      if (!out_ready) begin
        chk("stall_ir", in_ready, 0);
        chk("stall_ov", out_valid, 1);
        chk("stall_o", $signed(o), exp_s[k]);
      end
      if (in_valid && in_ready)
        i++;
      if (out_valid && out_ready) begin
        chk("stream_o", $signed(o), exp_s[k]);
        k++;
      end
      step;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_k", k, 8);
    chk("stream_cnt", res_cnt, 8);
    chk("stream_cnt_wrap", res_cnt2, 0);
    chk("stream_ov", out_valid, 0);

    out_ready = 1'b1;
    drive(2, 0, 3, 1'b0, 1'b1);
    step;
    drive(2, 7, 1, 1'b1, 1'b1);
    step;
    chk("acc_a", $signed(o), 3);
    drive(2, 0, 0, 1'b1, 1'b0);
    step;
    chk("acc_b", $signed(o), 2);
    in_valid = 1'b0;
    step;
    chk("acc_c", $signed(o), 1);
    step;

    out_ready = 1'b0;
    drive(1, 1, 1, 1'b0, 1'b1);
    step;
    drive(1, 1, 1, 1'b0, 1'b1);
    step;
    chk("fly_ov", out_valid, 1);
    chk("fly_o", $signed(o), 4);
    rst      = 1'b1;
    in_valid = 1'b0;
    step;
    chk("mid_ov", out_valid, 0);
    chk("mid_o", $signed(o), 0);
    chk("mid_cnt", res_cnt, 0);
    chk("mid_ir", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rel_ir", in_ready, 1);
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      step;
      if (out_valid)
        seen++;
    end
    chk("no_stale", seen, 0);
    single("acc_clr", 2, 5, 0, 1'b1, 1'b0, 0, 1, 0);
    step;
    chk("final_cnt", res_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
